// File: rtl/bus_reg_responder.sv
// ---------------------------------------------------------------------------
// bus_reg_responder
//
// Registered target end of the valid/addr/wdata/rdata/ready bus. Holds a
// NUM_REGS x DATA_W register file that an initiator reads and writes. Each
// request is captured in IDLE, optionally held for WAIT_CYCLES wait states,
// and completed with a single-cycle ready strobe. Accesses to addresses at or
// above NUM_REGS complete with err=1 and touch nothing.
//
// Optional feature macro: BUS_RESP_PARITY_EN
//   Adds even-parity protection on the data paths. A write whose wdata_par
//   disagrees with ^wdata completes with err=1 and is dropped. rdata_par
//   carries ^rdata while ready=1 and is 0 otherwise.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   valid      in   1       request, held with write/addr/wdata until ready
//   write      in   1       1 = write, 0 = read
//   addr       in   ADDR_W  register index
//   wdata      in   DATA_W  write data
//   wdata_par  in   1       even parity of wdata (BUS_RESP_PARITY_EN only)
//   rdata_par  out  1       even parity of rdata (BUS_RESP_PARITY_EN only)
//   rdata      out  DATA_W  read data, non-zero only while ready=1
//   ready      out  1       one-cycle completion strobe
//   err        out  1       qualifies ready: access failed
// ---------------------------------------------------------------------------
module bus_reg_responder #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 4,
   parameter int NUM_REGS    = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef BUS_RESP_PARITY_EN
   input  logic              wdata_par,
   output logic              rdata_par,
`endif
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              err
);

   localparam int CNT_W = 4;
   localparam int CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [ADDR_W:0] NUM_REGS_V = (ADDR_W + 1)'(NUM_REGS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  next_cnt;
   logic              capture;

   logic              cap_write;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_wdata;
`ifdef BUS_RESP_PARITY_EN
   logic              cap_wpar;
`endif

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rd_val;
   logic              in_range;
   logic              resp_err;
   logic              do_write;
   logic [DATA_W-1:0] rdata_d;

   // State and wait counter register. Reset drops any in-flight request,
   // including a write that has not yet committed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state logic. The counter is loaded so that WAIT lasts exactly
   // WAIT_CYCLES cycles. Dropping valid during WAIT abandons the request;
   // once in RESP the transaction always finishes.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      capture    = 1'b0;
      case (state)
         S_IDLE: begin
            if (valid) begin
               capture = 1'b1;
               if (WAIT_CYCLES > 0) begin
                  next_state = S_WAIT;
                  next_cnt   = CNT_W'(CNT_LOAD);
               end else begin
                  next_state = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (!valid) begin
               next_state = S_IDLE;
            end else if (cnt == '0) begin
               next_state = S_RESP;
            end else begin
               next_cnt = cnt - 1'b1;
            end
         end
         S_RESP: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Response decode for the captured request. Read data is picked with a
   // compare loop so the address width never has to match the register
   // count. Parity failures matter only for writes.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (cap_addr == ADDR_W'(i)) begin
            rd_val = regs[i];
         end
      end
      in_range = ({1'b0, cap_addr} < NUM_REGS_V);
      resp_err = !in_range;
`ifdef BUS_RESP_PARITY_EN
      if (cap_write && (cap_wpar != ^cap_wdata)) begin
         resp_err = 1'b1;
      end
`endif
      do_write = (state == S_RESP) && cap_write && !resp_err;
      rdata_d  = '0;
      if ((state == S_RESP) && !cap_write && !resp_err) begin
         rdata_d = rd_val;
      end
   end

   // Request capture and registered response outputs. The outputs are
   // loaded on the edge that leaves RESP, so ready appears WAIT_CYCLES+1
   // edges after capture. The IDLE cycle that follows guarantees ready
   // never stays high for two cycles in a row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         ready     <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
`ifdef BUS_RESP_PARITY_EN
         cap_wpar  <= 1'b0;
         rdata_par <= 1'b0;
`endif
      end else begin
         if (capture) begin
            cap_write <= write;
            cap_addr  <= addr;
            cap_wdata <= wdata;
`ifdef BUS_RESP_PARITY_EN
            cap_wpar  <= wdata_par;
`endif
         end
         ready <= (state == S_RESP);
         err   <= (state == S_RESP) && resp_err;
         rdata <= rdata_d;
`ifdef BUS_RESP_PARITY_EN
         rdata_par <= (state == S_RESP) ? ^rdata_d : 1'b0;
`endif
      end
   end

   // Register file. A write commits on the same edge that raises ready, so
   // any request captured afterwards already sees the new value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (do_write && (cap_addr == ADDR_W'(i))) begin
               regs[i] <= cap_wdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_bus_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_reg_responder
//
// Self-checking bench. Drives a WAIT_CYCLES=2 instance through directed and
// randomized requests and checks each response against a plain array model of
// the register file. A second, WAIT_CYCLES=0 instance covers back-to-back
// requests with valid held high.
// ---------------------------------------------------------------------------
module tb_bus_reg_responder;

   localparam int ADDR_W      = 4;
   localparam int DATA_W      = 4;
   localparam int NUM_REGS    = 12;
   localparam int WAIT_CYCLES = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              valid = 1'b0;
   logic              valid0 = 1'b0;
   logic              write = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] wdata = '0;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] rdata0;
   logic              ready;
   logic              ready0;
   logic              err;
   logic              err0;
`ifdef BUS_RESP_PARITY_EN
   logic              wdata_par;
   logic              rdata_par;
   logic              rdata_par0;
   assign wdata_par = ^wdata;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DATA_W-1:0] model [NUM_REGS];

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   bus_reg_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
      .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .write(write),
      .addr(addr), .wdata(wdata),
`ifdef BUS_RESP_PARITY_EN
      .wdata_par(wdata_par), .rdata_par(rdata_par),
`endif
      .rdata(rdata), .ready(ready), .err(err)
   );

   bus_reg_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
      .WAIT_CYCLES(0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .valid(valid0), .write(write),
      .addr(addr), .wdata(wdata),
`ifdef BUS_RESP_PARITY_EN
      .wdata_par(wdata_par), .rdata_par(rdata_par0),
`endif
      .rdata(rdata0), .ready(ready0), .err(err0)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic nextEdge();
      @(posedge clk);
      #1;
   endtask

   // One complete request on the WAIT_CYCLES=2 instance. When scramble is
   // set, the request inputs are randomized right after capture while valid
   // stays high; the response must still reflect the captured request.
   task automatic applyStimulus(input logic w, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input bit scramble);
      logic              exp_err;
      logic [DATA_W-1:0] exp_rdata;
      exp_err   = (int'(a) >= NUM_REGS);
      exp_rdata = '0;
      if (!w && !exp_err) begin
         exp_rdata = model[a];
      end
      write = w;
      addr  = a;
      wdata = d;
      valid = 1'b1;
      nextEdge();
      if (scramble) begin
         write = 1'($urandom);
         addr  = ADDR_W'($urandom);
         wdata = DATA_W'($urandom);
      end
      for (int k = 1; k <= WAIT_CYCLES + 1; k++) begin
         nextEdge();
         if (k <= WAIT_CYCLES) begin
            checkOutput("ready_early", {31'd0, ready}, 32'd0);
         end
      end
      checkOutput("ready", {31'd0, ready}, 32'd1);
      checkOutput("err", {31'd0, err}, {31'd0, exp_err});
      checkOutput("rdata", {28'd0, rdata}, {28'd0, exp_rdata});
`ifdef BUS_RESP_PARITY_EN
      checkOutput("rdata_par", {31'd0, rdata_par}, {31'd0, ^exp_rdata});
`endif
      valid = 1'b0;
      if (w && !exp_err) begin
         model[a] = d;
      end
      nextEdge();
      checkOutput("ready_gap", {31'd0, ready}, 32'd0);
      checkOutput("rdata_idle", {28'd0, rdata}, 32'd0);
   endtask

   // Request that is withdrawn one cycle after capture: no response, and a
   // withdrawn write must not land.
   task automatic abortStimulus(input logic w, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d);
      write = w;
      addr  = a;
      wdata = d;
      valid = 1'b1;
      nextEdge();
      valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         nextEdge();
         checkOutput("abort_ready", {31'd0, ready}, 32'd0);
      end
   endtask

   initial begin
      logic [DATA_W-1:0] v;
      for (int i = 0; i < NUM_REGS; i++) begin
         model[i] = '0;
      end

      // Asynchronous reset, checked before any clock edge.
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #2;
      checkOutput("reset_ready", {31'd0, ready}, 32'd0);
      checkOutput("reset_err", {31'd0, err}, 32'd0);
      checkOutput("reset_rdata", {28'd0, rdata}, 32'd0);
      checkOutput("reset_ready0", {31'd0, ready0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nextEdge();

      // Directed: fresh read, write/read back, out of range, abort.
      applyStimulus(1'b0, 4'd3, 4'h0, 1'b0);
      applyStimulus(1'b1, 4'd5, 4'hA, 1'b0);
      applyStimulus(1'b0, 4'd5, 4'h0, 1'b0);
      applyStimulus(1'b1, 4'hC, 4'h7, 1'b0);
      applyStimulus(1'b0, 4'hC, 4'h0, 1'b0);
      abortStimulus(1'b1, 4'd5, 4'h3);
      applyStimulus(1'b0, 4'd5, 4'h0, 1'b0);

      // Zero wait states, valid held: write then back-to-back reads.
      v = DATA_W'($urandom_range(1, 15));
      write  = 1'b1;
      addr   = 4'd7;
      wdata  = v;
      valid0 = 1'b1;
      nextEdge();
      for (int k = 1; k <= 7; k++) begin
         nextEdge();
         checkOutput("b2b_ready", {31'd0, ready0}, (k % 2 == 1) ? 32'd1 : 32'd0);
         if (k % 2 == 1) begin
            checkOutput("b2b_err", {31'd0, err0}, 32'd0);
            checkOutput("b2b_rdata", {28'd0, rdata0}, (k == 1) ? 32'd0 : {28'd0, v});
         end
         if (k == 1) begin
            write = 1'b0;
         end
         if (k == 7) begin
            valid0 = 1'b0;
         end
      end
      nextEdge();
      checkOutput("b2b_done", {31'd0, ready0}, 32'd0);

      // Reset while a write of 4'hF to addr 2 is waiting.
      write = 1'b1;
      addr  = 4'd2;
      wdata = 4'hF;
      valid = 1'b1;
      nextEdge();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_ready", {31'd0, ready}, 32'd0);
      checkOutput("midrst_err", {31'd0, err}, 32'd0);
      checkOutput("midrst_rdata", {28'd0, rdata}, 32'd0);
      valid = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         model[i] = '0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      nextEdge();
      for (int k = 0; k < 3; k++) begin
         nextEdge();
         checkOutput("midrst_quiet", {31'd0, ready}, 32'd0);
      end
      applyStimulus(1'b0, 4'd2, 4'h0, 1'b0);

      // Randomized traffic with occasional aborts and mid-request input churn.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            abortStimulus(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
         end else begin
            applyStimulus(1'($urandom), ADDR_W'($urandom_range(0, 15)),
                          DATA_W'($urandom), 1'($urandom));
         end
         repeat ($urandom_range(0, 2)) nextEdge();
      end

      // Final sweep: every register must match the model.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, ADDR_W'(i), 4'h0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
